// File: rtl/bcd_counter_scan_pkg.sv
// Shared constants and 7-segment decode for the BCD counter/scan slice.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_counter_scan_pkg;

  localparam int          DIGIT_W   = 4;
  localparam logic [3:0]  BCD_MAX   = 4'd9;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal decade: clear, saturating preset, and up/down step with
// carry/borrow out to the next decade.
module bcd_digit
  import bcd_counter_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_nib,
  input  logic               step_in,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               step_out
);

  assign step_out = step_in && (up ? (q == BCD_MAX) : (q == '0));

  // Non-decimal preset nibbles saturate to 9 so the display never sees them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= (load_nib > BCD_MAX) ? BCD_MAX : load_nib;
    end else if (step_in) begin
      if (up) q <= (q == BCD_MAX) ? '0 : q + 1'b1;
      else    q <= (q == '0) ? BCD_MAX : q - 1'b1;
    end
  end

endmodule

// File: rtl/bcd_counter_scan.sv
// N-digit BCD up/down counter with clock-enable prescalers and a
// multiplexed, optionally zero-blanked 7-segment scan output.
module bcd_counter_scan
  import bcd_counter_scan_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int COUNT_DIV = 50_000_000,
  parameter int SCAN_DIV  = 50_000,
  parameter int BLANK_LZ  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic                        up,
  input  logic                        clr,
  input  logic                        load,
  input  logic [DIGIT_W*N_DIGITS-1:0] load_val,
  output logic [DIGIT_W*N_DIGITS-1:0] count,
  output logic                        tick,
  output logic                        wrap,
  output logic [N_DIGITS-1:0]         seg_sel,
  output logic [6:0]                  seg_data
);

  localparam int PC_W  = $clog2(COUNT_DIV);
  localparam int SC_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PC_W-1:0]  PC_MAX  = PC_W'(COUNT_DIV - 1);
  localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

  logic [PC_W-1:0]    pc;
  logic [SC_W-1:0]    sc;
  logic [IDX_W-1:0]   idx;
  logic [N_DIGITS:0]  carry;
  logic               step;
  logic [DIGIT_W-1:0] sel_nib;
  logic               sel_blank;
  logic               higher_zero;

  assign step     = run && !clr && !load && (pc == PC_MAX);
  assign carry[0] = step;

  // clr/load park the prescaler at 0 so a step is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pc <= '0;
    else if (clr || load) pc <= '0;
    else if (run)         pc <= (pc == PC_MAX) ? '0 : pc + 1'b1;
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (load),
      .load_nib (load_val[k*DIGIT_W +: DIGIT_W]),
      .step_in  (carry[k]),
      .up       (up),
      .q        (count[k*DIGIT_W +: DIGIT_W]),
      .step_out (carry[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= step;
      wrap <= carry[N_DIGITS];
    end
  end

  // Scan timing is free-running and independent of the counting controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc  <= '0;
      idx <= '0;
    end else if (sc == SC_MAX) begin
      sc  <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      sc <= sc + 1'b1;
    end
  end

  // Walk from the top digit down so higher_zero covers the digit and all above it.
  always_comb begin
    sel_nib     = '0;
    sel_blank   = 1'b0;
    higher_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      higher_zero = higher_zero && (count[k*DIGIT_W +: DIGIT_W] == '0);
      if (idx == IDX_W'(k)) begin
        sel_nib   = count[k*DIGIT_W +: DIGIT_W];
        sel_blank = (BLANK_LZ != 0) && (k != 0) && higher_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sel  <= ~N_DIGITS'(1);
      seg_data <= seg_decode(4'd0);
    end else begin
      seg_sel  <= ~(N_DIGITS'(1) << idx);
      seg_data <= sel_blank ? SEG_BLANK : seg_decode(sel_nib);
    end
  end

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// integer-valued reference model of the counter and scanned display.
module tb_bcd_counter_scan;

  localparam int ND   = 4;
  localparam int CDIV = 4;
  localparam int SDIV = 3;
  localparam int MODV = 10000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count, count_nb;
  logic        tick, wrap, tick_nb, wrap_nb;
  logic [3:0]  seg_sel, seg_sel_nb;
  logic [6:0]  seg_data, seg_data_nb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_counter_scan #(.N_DIGITS(ND), .COUNT_DIV(CDIV), .SCAN_DIV(SDIV), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count), .tick(tick), .wrap(wrap),
    .seg_sel(seg_sel), .seg_data(seg_data)
  );

  bcd_counter_scan #(.N_DIGITS(ND), .COUNT_DIV(CDIV), .SCAN_DIV(SDIV), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .run(run), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count_nb), .tick(tick_nb), .wrap(wrap_nb),
    .seg_sel(seg_sel_nb), .seg_data(seg_data_nb)
  );

  // Standard active-low {g,f,e,d,c,b,a} codes for 0..9.
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic int p10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
    return r;
  endfunction

  function automatic int clamp_val(input logic [15:0] lv);
    int s = 0;
    int n;
    for (int k = 0; k < ND; k++) begin
      n = int'(lv[4*k +: 4]);
      if (n > 9) n = 9;
      s += n * p10(k);
    end
    return s;
  endfunction

  // Reference model: the count is a plain integer 0..9999.
  int         m_val = 0, m_pc = 0, m_sc = 0, m_idx = 0, m_d;
  bit         m_tick = 0, m_wrap = 0;
  logic [3:0] m_sel = 4'b1110;
  logic [6:0] m_data_b = 7'b1000000, m_data_nb = 7'b1000000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val = 0; m_pc = 0; m_sc = 0; m_idx = 0; m_tick = 0; m_wrap = 0;
      m_sel = 4'b1110; m_data_b = 7'b1000000; m_data_nb = 7'b1000000;
    end else begin
      m_d       = (m_val / p10(m_idx)) % 10;
      m_sel     = ~(4'b0001 << m_idx);
      m_data_nb = seg_tab[m_d];
      m_data_b  = (m_idx != 0 && m_val < p10(m_idx)) ? 7'b1111111 : seg_tab[m_d];
      m_tick = 0; m_wrap = 0;
      if (clr) begin
        m_val = 0; m_pc = 0;
      end else if (load) begin
        m_val = clamp_val(load_val); m_pc = 0;
      end else if (run) begin
        if (m_pc == CDIV - 1) begin
          m_pc = 0; m_tick = 1;
          if (up) begin m_wrap = (m_val == MODV - 1); m_val = (m_val + 1) % MODV; end
          else    begin m_wrap = (m_val == 0); m_val = (m_val + MODV - 1) % MODV; end
        end else begin
          m_pc++;
        end
      end
      if (m_sc == SDIV - 1) begin m_sc = 0; m_idx = (m_idx + 1) % ND; end
      else m_sc++;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (count !== 16'h0000) begin failures++; $display("FAIL reset_count got=%h exp=0000", count); end
    checks++; if (tick !== 1'b0 || wrap !== 1'b0) begin failures++; $display("FAIL reset_pulses got tick=%b wrap=%b exp 0 0", tick, wrap); end
    checks++; if (seg_sel !== 4'b1110) begin failures++; $display("FAIL reset_seg_sel got=%b exp=1110", seg_sel); end
    checks++; if (seg_data !== 7'b1000000) begin failures++; $display("FAIL reset_seg_data got=%b exp=1000000", seg_data); end
  endtask

  task automatic test_count_up();
    int n;
    run = 1'b1; up = 1'b1; rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (tick !== (i == 4)) begin failures++; $display("FAIL first_step_tick cycle=%0d got=%b exp=%b", i, tick, (i == 4)); end
    end
    checks++; if (count !== 16'h0001) begin failures++; $display("FAIL first_step_count got=%h exp=0001", count); end
    for (n = 0; n < 200 && count !== 16'h0009; n++) @(negedge clk);
    checks++; if (count !== 16'h0009) begin failures++; $display("FAIL reach_9 got=%h exp=0009", count); end
    for (n = 0; n < 8; n++) begin @(negedge clk); if (tick) break; end
    checks++; if (count !== 16'h0010 || tick !== 1'b1) begin failures++; $display("FAIL carry_9_to_10 got=%h tick=%b exp=0010 tick=1", count, tick); end
  endtask

  task automatic test_wrap();
    int n;
    @(negedge clk); load = 1'b1; load_val = 16'h9999; up = 1'b1; run = 1'b1;
    @(negedge clk); load = 1'b0;
    checks++; if (count !== 16'h9999 || tick !== 1'b0) begin failures++; $display("FAIL load_9999 got=%h tick=%b exp=9999 tick=0", count, tick); end
    for (n = 0; n < 8; n++) begin @(negedge clk); if (tick) break; end
    checks++; if (count !== 16'h0000 || wrap !== 1'b1 || tick !== 1'b1) begin failures++; $display("FAIL wrap_up got=%h wrap=%b tick=%b exp=0000 1 1", count, wrap, tick); end
    up = 1'b0;
    @(negedge clk);
    checks++; if (wrap !== 1'b0 || tick !== 1'b0) begin failures++; $display("FAIL wrap_one_cycle got wrap=%b tick=%b exp 0 0", wrap, tick); end
    for (n = 0; n < 8; n++) begin @(negedge clk); if (tick) break; end
    checks++; if (count !== 16'h9999 || wrap !== 1'b1) begin failures++; $display("FAIL wrap_down got=%h wrap=%b exp=9999 1", count, wrap); end
  endtask

  task automatic test_load_clamp();
    @(negedge clk); load = 1'b1; load_val = 16'h12F4; run = 1'b0;
    @(negedge clk); load = 1'b0;
    checks++; if (count !== 16'h1294) begin failures++; $display("FAIL load_clamp got=%h exp=1294", count); end
    clr = 1'b1; load = 1'b1; load_val = 16'h5555; run = 1'b1;
    @(negedge clk); clr = 1'b0; load = 1'b0;
    checks++; if (count !== 16'h0000 || tick !== 1'b0 || wrap !== 1'b0) begin failures++; $display("FAIL clr_over_load got=%h tick=%b wrap=%b exp=0000 0 0", count, tick, wrap); end
  endtask

  task automatic test_run_gate();
    bit pat [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    clr = 1'b1; run = 1'b0; up = 1'b1;
    @(negedge clk); clr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run = pat[i];
      @(negedge clk);
      checks++;
      if (tick !== (i == 6) || count !== ((i == 6) ? 16'h0001 : 16'h0000)) begin
        failures++; $display("FAIL run_gate cycle=%0d got tick=%b count=%h exp tick=%b", i, tick, count, (i == 6));
      end
    end
    run = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] exp_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] exp_b   [4] = '{7'b0010010, 7'b1000000, 7'b0110000, 7'b1111111};
    logic [6:0] exp_nb  [4] = '{7'b0010010, 7'b1000000, 7'b0110000, 7'b1000000};
    int n;
    @(negedge clk); load = 1'b1; load_val = 16'h0305; run = 1'b0; clr = 1'b0;
    @(negedge clk); load = 1'b0;
    for (n = 0; n < 20 && seg_sel === 4'b1110; n++) @(negedge clk);
    for (n = 0; n < 20 && seg_sel !== 4'b1110; n++) @(negedge clk);
    checks++; if (seg_sel !== 4'b1110) begin failures++; $display("FAIL scan_sync got=%b exp=1110", seg_sel); end
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < SDIV; c++) begin
        checks++;
        if (seg_sel !== exp_sel[d] || seg_data !== exp_b[d] || seg_data_nb !== exp_nb[d]) begin
          failures++;
          $display("FAIL scan digit=%0d cyc=%0d got sel=%b blank_data=%b plain_data=%b exp %b %b %b",
                   d, c, seg_sel, seg_data, seg_data_nb, exp_sel[d], exp_b[d], exp_nb[d]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (count !== to_bcd(m_val) || count_nb !== to_bcd(m_val) || tick !== m_tick || wrap !== m_wrap
          || tick_nb !== m_tick || wrap_nb !== m_wrap) begin
        failures++;
        $display("FAIL rand_count i=%0d got=%h/%h tick=%b wrap=%b exp=%h tick=%b wrap=%b",
                 i, count, count_nb, tick, wrap, to_bcd(m_val), m_tick, m_wrap);
      end
      checks++;
      if (seg_sel !== m_sel || seg_sel_nb !== m_sel || seg_data !== m_data_b || seg_data_nb !== m_data_nb) begin
        failures++;
        $display("FAIL rand_display i=%0d got sel=%b data=%b/%b exp sel=%b data=%b/%b",
                 i, seg_sel, seg_data, seg_data_nb, m_sel, m_data_b, m_data_nb);
      end
      r        = $urandom_range(0, 99);
      clr      = (r < 3);
      load     = (r >= 3 && r < 8);
      load_val = 16'($urandom);
      run      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
    end
    clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk); load = 1'b1; load_val = 16'h0042; run = 1'b0;
    @(negedge clk); load = 1'b0; run = 1'b1; up = 1'b1;
    @(negedge clk);
    checks++; if (count !== 16'h0042) begin failures++; $display("FAIL pre_reset_count got=%h exp=0042", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 16'h0000 || tick !== 1'b0 || wrap !== 1'b0 || seg_sel !== 4'b1110 || seg_data !== 7'b1000000) begin
      failures++;
      $display("FAIL async_reset got count=%h tick=%b wrap=%b sel=%b data=%b exp 0000 0 0 1110 1000000",
               count, tick, wrap, seg_sel, seg_data);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (tick !== (i == 4)) begin failures++; $display("FAIL post_reset_step cycle=%0d got=%b exp=%b", i, tick, (i == 4)); end
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_load_clamp();
    test_run_gate();
    test_scan();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
